serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Serial-to-parallel receiver for the modulation datapath, the receiving end of the MSB-first parallel-load shift-out link. Collects WIDTH bits from `serial_in`, one per `shift_en` strobe and MSB first, then presents the assembled word on `data_out` with a one-cycle `data_valid` pulse. `start` may share a wire with the transmitter's `ld_shiftreg`, and `shift_en` with the transmitter's `shift_en`.

## Interface
- `WIDTH`, default 9, word length in bits; legal range is WIDTH ≥ 2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low reset, sampled on rising `clk`; 0 = reset.
- `start`  input  1  frame start; clears the bit counter and arms reception.
- `shift_en`  input  1  bit strobe; `serial_in` is sampled on an edge where this is 1 and the block is receiving.
- `serial_in`  input  1  serial data, MSB first.
- `data_out`  output  WIDTH  last completed word; holds until the next frame completes.
- `data_valid`  output  1  one-cycle pulse; `data_out` has just been updated.
- `busy`  output  1  high while in RECV.
- `frame_err`  output  1  one-cycle pulse; a frame was aborted by `start` before completion.

## Operation
- Internal state:
  - FSM states IDLE and RECV.
  - Shift register `shreg[WIDTH-1:0]`.
  - Bit counter `cnt`, $clog2(WIDTH) bits.
- Reset (`reset`=0 at an edge):
  - State goes to IDLE.
  - `shreg`, `cnt` and `data_out` go to 0.
  - `data_valid`, `frame_err` and `busy` go to 0.
  - Reset overrides every other input, including mid-frame; the partial word is discarded and no `frame_err` is raised.
- IDLE:
  - `shift_en` and `serial_in` are ignored.
  - `start`=1 → go to RECV, with `cnt`←0 and `shreg`←0.
- RECV with `start`=0 and `shift_en`=1:
  - `shreg` ← {`shreg`[WIDTH-2:0], `serial_in`} and `cnt` ← `cnt`+1.
  - If `cnt` = WIDTH-1: `data_out` ← {`shreg`[WIDTH-2:0], `serial_in`}, `data_valid` ← 1, state ← IDLE, `cnt` ← 0.
- RECV with `start`=0 and `shift_en`=0: hold all state.
- RECV with `start`=1: restart the frame.
  - `cnt`←0, `shreg`←0, `frame_err`←1, and the state stays RECV.
  - `start` has priority over `shift_en` on the same edge; that edge's bit is not sampled.
  - `data_out` is not changed.
- `data_valid` and `frame_err` are registered and default to 0 on every edge where they are not set.
- `busy` = (state == RECV), driven from a register.
- The counter never exceeds WIDTH-1, so there is no wrap inside a frame.

## Timing
- Sampling and latency:
  - A bit is sampled on the same rising edge at which the transmitter shifts. The value present on `serial_in` before that edge is captured.
  - Latency: `data_out` and `data_valid` change on the edge that samples bit WIDTH-1 (the LSB). They are visible in the following cycle.
- Frame length:
  - Minimum frame is 1 `start` cycle plus WIDTH `shift_en` cycles, so the `data_valid` pulse appears WIDTH+1 edges after `start`.
  - `shift_en` may have gaps of any length; the frame simply stalls.
- Back-to-back operation:
  - `start` may be asserted in the cycle where `data_valid`=1 (state is already IDLE); the next frame begins without a lost cycle.
  - `data_valid` is never high for two consecutive cycles.
- `start` in IDLE never raises `frame_err`.
- Pairing with the shift-out transmitter: tie `start` to `ld_shiftreg`, tie `shift_en` to `shift_en`, and tie `serial_in` to `Shift_out`. The loaded word is then reproduced exactly on `data_out`.

## Test plan
- **Reset:**
  - Stimulus: hold `reset`=0 for 2 cycles with random inputs.
  - Required response: `data_out`=0, `data_valid`=0, `busy`=0, `frame_err`=0.
  - Then release `reset` and assert `shift_en` with no `start`; the outputs stay 0.
- **Basic frame (WIDTH=9):**
  - Stimulus: `start`, then 9 consecutive `shift_en` cycles with bits 1,0,1,1,0,0,1,0,1.
  - Required response: `data_out`=9'h165; `data_valid` high for exactly 1 cycle, 10 edges after `start`; `busy` low afterwards.
- **Gapped strobes:**
  - Stimulus: the same bits as the basic frame, with `shift_en` low for 3 cycles between each bit.
  - Required response: `data_out`=9'h165; `data_valid` only after the 9th strobe.
- **Abort:**
  - Stimulus: `start`, 4 bits, then `start` together with `shift_en`=1, then 9 bits encoding 9'h0AA.
  - Required response: one `frame_err` pulse; no `data_valid` for the aborted frame; final `data_out`=9'h0AA.
- **Back-to-back:**
  - Stimulus: word 9'h1FF, then `start` in the cycle where `data_valid`=1, then word 9'h000.
  - Required response: two `data_valid` pulses, with `data_out` equal to 1FF and then 000.
- **Loopback:**
  - Stimulus: drive the transmitter with random words, wired to this block as in Timing; run 200 words; repeat with reset=0 pulsed mid-frame.
  - Required response: each `data_out` equals the loaded word. After the mid-frame reset, `data_out`=0 and there is no `data_valid` until a complete new frame.

Source files
------------

// File: rtl/serial_word_receiver.sv
// ============================================================================
//  Module   : serial_word_receiver
//  Purpose  : MSB-first serial-to-parallel word receiver with frame abort flag
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_receiver #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx, shifted;
    logic [WIDTH-1:0] data_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             valid_nx, err_nx;

    assign shifted = {shreg[WIDTH-2:0], serial_in};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            cnt        <= cnt_nx;
            data_out   <= data_nx;
            data_valid <= valid_nx;
            frame_err  <= err_nx;
            busy       <= (state_nx == RECV);
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        data_nx  = data_out;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RECV;
                    shreg_nx = '0;
                    cnt_nx   = '0;
                end
            end
            RECV: begin
                // A restart wins over a strobe on the same edge; that bit is dropped.
                if (start) begin
                    shreg_nx = '0;
                    cnt_nx   = '0;
                    err_nx   = 1'b1;
                end else if (shift_en) begin
                    shreg_nx = shifted;
                    if (cnt == LAST_BIT) begin
                        data_nx  = shifted;
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
// ============================================================================
//  Module   : tb_serial_word_receiver
//  Purpose  : directed + randomized bench against a bit-queue frame model
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_word_receiver;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         shift_en = 1'b0;
    logic         serial_in = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         frame_err;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is a queue of received bits.
    bit           m_active = 1'b0;
    bit           m_bits[$];
    logic [W-1:0] m_out = '0;
    bit           m_valid = 1'b0;
    bit           m_err = 1'b0;

    serial_word_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic se, input logic si);
        logic [W-1:0] w;
        start     = st;
        shift_en  = se;
        serial_in = si;
        @(posedge clk);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!reset) begin
            m_active = 1'b0;
            m_bits.delete();
            m_out = '0;
        end else if (st) begin
            m_err    = m_active;
            m_active = 1'b1;
            m_bits.delete();
        end else if (m_active && se) begin
            m_bits.push_back(si);
            if (m_bits.size() == W) begin
                w = '0;
                foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
                m_out    = w;
                m_valid  = 1'b1;
                m_active = 1'b0;
                m_bits.delete();
            end
        end
        #1;
        check("data_out",   32'(data_out),   32'(m_out));
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("frame_err",  32'(frame_err),  32'(m_err));
        check("busy",       32'(busy),       32'(m_active));
    endtask

    // Transmitter stand-in: load on start, then present MSB first with optional idle gaps.
    task automatic send_word(input logic [W-1:0] w, input int gmin, input int gmax);
        int g;
        step(1'b1, 1'($urandom), 1'($urandom));
        for (int i = W - 1; i >= 0; i--) begin
            if (i != W - 1) begin
                g = int'($urandom_range(gmax, gmin));
                for (int k = 0; k < g; k++) step(1'b0, 1'b0, 1'($urandom));
            end
            step(1'b0, 1'b1, w[i]);
        end
    endtask

    initial begin
        logic [W-1:0] w;

        // Reset held with random activity
        reset = 1'b0;
        step(1'($urandom), 1'($urandom), 1'($urandom));
        step(1'($urandom), 1'($urandom), 1'($urandom));
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_valid",    32'(data_valid), 32'h0);
        check("rst_busy",     32'(busy), 32'h0);
        check("rst_err",      32'(frame_err), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom));
        check("idle_data_out", 32'(data_out), 32'h0);

        // Basic frame: pulse visible right after the 10th edge from start
        send_word(9'h165, 0, 0);
        check("basic_valid", 32'(data_valid), 32'h1);
        check("basic_data",  32'(data_out), 32'h165);
        step(1'b0, 1'b0, 1'b0);
        check("basic_pulse_end", 32'(data_valid), 32'h0);
        check("basic_busy_low",  32'(busy), 32'h0);

        // Gapped strobes
        send_word(9'h165, 3, 3);
        check("gap_valid", 32'(data_valid), 32'h1);
        check("gap_data",  32'(data_out), 32'h165);
        step(1'b0, 1'b0, 1'b0);

        // Abort: restart collides with a strobe
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'($urandom));
        step(1'b1, 1'b1, 1'b1);
        check("abort_err",   32'(frame_err), 32'h1);
        check("abort_busy",  32'(busy), 32'h1);
        check("abort_keep",  32'(data_out), 32'h165);
        w = 9'h0AA;
        for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, w[i]);
        check("abort_valid", 32'(data_valid), 32'h1);
        check("abort_data",  32'(data_out), 32'h0AA);

        // Back-to-back: next start lands in the data_valid cycle
        send_word(9'h1FF, 0, 0);
        check("b2b_valid1", 32'(data_valid), 32'h1);
        check("b2b_data1",  32'(data_out), 32'h1FF);
        send_word(9'h000, 0, 0);
        check("b2b_valid2", 32'(data_valid), 32'h1);
        check("b2b_data2",  32'(data_out), 32'h000);
        check("b2b_no_err", 32'(frame_err), 32'h0);

        // Loopback with random words and random gaps
        for (int n = 0; n < 200; n++) begin
            w = W'($urandom);
            send_word(w, 0, 2);
            check("loop_valid", 32'(data_valid), 32'h1);
            check("loop_data",  32'(data_out), 32'(w));
            if ($urandom_range(3, 0) == 0) step(1'b0, 1'($urandom), 1'($urandom));
        end

        // Mid-frame reset discards the partial word silently
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom));
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_err",  32'(frame_err), 32'h0);
        for (int i = 0; i < W + 2; i++) step(1'b0, 1'b1, 1'($urandom));
        check("mid_rst_no_valid", 32'(data_valid), 32'h0);
        check("mid_rst_hold",     32'(data_out), 32'h0);
        for (int n = 0; n < 20; n++) begin
            w = W'($urandom);
            send_word(w, 0, 1);
            check("post_rst_data", 32'(data_out), 32'(w));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
